// File: rtl/audio_playback_ctrl.sv
// Playback sequencer for the 8-bit audio sample memory: play/stop/pause, clip window,
// looping and Q2.2 variable speed, feeding the PWM comparator one sample per tick.
module audio_playback_ctrl #(
  parameter int         ADDR_W  = 18,
  parameter int         RD_LAT  = 1,
  parameter logic [7:0] SILENCE = 8'h80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  input  logic              cmd_pause,
  input  logic              loop_en,
  input  logic [3:0]        speed,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [7:0]        sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    PLAY_WAIT,
    PAUSED
  } state_t;

  localparam int PH_W  = ADDR_W + 2;
  localparam int LAT_W = $clog2(RD_LAT + 1);

  state_t            state, state_d;
  logic [PH_W-1:0]   phase, phase_d;
  logic [ADDR_W-1:0] start_r, start_d;
  logic [ADDR_W-1:0] end_r, end_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_rd_d;
  logic [7:0]        sample_out_d;
  logic              sample_valid_d;
  logic              done_d;
  logic              tick_pend, tick_pend_d;
  logic              pause_pend, pause_pend_d;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;

  // One extra bit on the sum so stepping past the top of memory still compares as "past end".
  logic [PH_W:0]     phase_sum;
  logic [ADDR_W:0]   sum_int;
  logic              sum_past_end;
  logic              play_ok;
  logic              pause_cmd;
  logic              tick_now;

  assign phase_sum    = {1'b0, phase} + {{(PH_W - 3){1'b0}}, speed};
  assign sum_int      = phase_sum[PH_W:2];
  assign sum_past_end = sum_int > {1'b0, end_r};
  assign play_ok      = cmd_play && (start_addr <= end_addr);
  assign pause_cmd    = cmd_pause && (state != IDLE);
  assign tick_now     = sample_tick || tick_pend;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    state_d        = state;
    phase_d        = phase;
    start_d        = start_r;
    end_d          = end_r;
    mem_addr_d     = mem_addr;
    mem_rd_d       = 1'b0;
    sample_out_d   = sample_out;
    sample_valid_d = 1'b0;
    done_d         = 1'b0;
    tick_pend_d    = tick_pend;
    pause_pend_d   = pause_pend;
    lat_cnt_d      = lat_cnt;

    if (cmd_stop) begin
      state_d      = IDLE;
      sample_out_d = SILENCE;
      tick_pend_d  = 1'b0;
      pause_pend_d = 1'b0;
    end else if (pause_cmd && (state == PLAY_WAIT)) begin
      state_d      = PAUSED;
      sample_out_d = SILENCE;
      tick_pend_d  = 1'b0;
    end else if (pause_cmd && (state == PAUSED)) begin
      state_d = FETCH;
    end else if (play_ok && !pause_cmd) begin
      // Restart; leaving WAIT_DATA drops any read still in flight.
      start_d      = start_addr;
      end_d        = end_addr;
      phase_d      = {start_addr, 2'b00};
      state_d      = FETCH;
      tick_pend_d  = 1'b0;
      pause_pend_d = 1'b0;
    end else begin
      // Only FETCH and WAIT_DATA can still carry a pause here; it waits for the sample.
      if (pause_cmd) pause_pend_d = 1'b1;

      unique case (state)
        FETCH: begin
          mem_addr_d = phase[PH_W-1:2];
          mem_rd_d   = 1'b1;
          lat_cnt_d  = '0;
          state_d    = WAIT_DATA;
          if (sample_tick) tick_pend_d = 1'b1;
        end
        WAIT_DATA: begin
          if (sample_tick) tick_pend_d = 1'b1;
          if (lat_cnt == LAT_W'(RD_LAT)) begin
            sample_out_d   = mem_data;
            sample_valid_d = 1'b1;
            if (pause_pend_d) begin
              state_d      = PAUSED;
              pause_pend_d = 1'b0;
              tick_pend_d  = 1'b0;
            end else begin
              state_d = PLAY_WAIT;
            end
          end else begin
            lat_cnt_d = lat_cnt + LAT_W'(1);
          end
        end
        PLAY_WAIT: begin
          if (tick_now) begin
            tick_pend_d = 1'b0;
            if (!sum_past_end) begin
              phase_d = phase_sum[PH_W-1:0];
              state_d = FETCH;
            end else if (loop_en) begin
              phase_d = {start_r, 2'b00};
              state_d = FETCH;
            end else begin
              done_d       = 1'b1;
              sample_out_d = SILENCE;
              state_d      = IDLE;
            end
          end
        end
        PAUSED: begin
          // A sample captured on the way into pause is shown for one cycle, then muted.
          sample_out_d = SILENCE;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= '0;
      start_r      <= '0;
      end_r        <= '0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      sample_out   <= SILENCE;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      tick_pend    <= 1'b0;
      pause_pend   <= 1'b0;
      lat_cnt      <= '0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop updates from pre-edge values.
      state        <= state_d;
      phase        <= phase_d;
      start_r      <= start_d;
      end_r        <= end_d;
      mem_addr     <= mem_addr_d;
      mem_rd       <= mem_rd_d;
      sample_out   <= sample_out_d;
      sample_valid <= sample_valid_d;
      done         <= done_d;
      busy         <= (state_d != IDLE);
      tick_pend    <= tick_pend_d;
      pause_pend   <= pause_pend_d;
      lat_cnt      <= lat_cnt_d;
    end
  end

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Directed bench for audio_playback_ctrl: expected samples are queued as stimulus is
// driven and popped by a monitor whenever sample_valid pulses.
module tb_audio_playback_ctrl;

  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_tick;
  logic              cmd_play;
  logic              cmd_stop;
  logic              cmd_pause;
  logic              loop_en;
  logic [3:0]        speed;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic [7:0]        sample_out;
  logic              sample_valid;
  logic              busy;
  logic              done;

  int n_tests   = 0;
  int n_fail    = 0;
  int n_valid   = 0;
  int n_done    = 0;
  int exp_valid = 0;
  int rd_count  = 0;
  logic [7:0] exp_q[$];

  audio_playback_ctrl #(
    .ADDR_W (ADDR_W),
    .RD_LAT (1),
    .SILENCE(8'h80)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .cmd_play    (cmd_play),
    .cmd_stop    (cmd_stop),
    .cmd_pause   (cmd_pause),
    .loop_en     (loop_en),
    .speed       (speed),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Sample memory: mem(a) = a[7:0], one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= mem_addr[7:0];
      rd_count <= rd_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sample_valid) begin
      n_valid++;
      if (exp_q.size() == 0) check("unexpected_sample", 32'(sample_out), 32'hFFFF_FFFF);
      else check("sample", 32'(sample_out), 32'(exp_q.pop_front()));
    end
    if (done) n_done++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic play(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                      input logic [3:0] spd, input logic lp);
    start_addr = s;
    end_addr   = e;
    speed      = spd;
    loop_en    = lp;
    cmd_play   = 1'b1;
    cyc();
    cmd_play   = 1'b0;
  endtask

  task automatic expect_sample(input logic [7:0] v);
    exp_q.push_back(v);
    exp_valid++;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (n_valid < exp_valid && k < 40) begin
      cyc();
      k++;
    end
    check("valid_count", 32'(n_valid), 32'(exp_valid));
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic tick_sample(input logic [7:0] v);
    expect_sample(v);
    tick();
    wait_valid();
  endtask

  task automatic tick_done();
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_silence", 32'(sample_out), 32'h80);
    cyc();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic pause();
    cmd_pause = 1'b1;
    cyc();
    cmd_pause = 1'b0;
  endtask

  task automatic stop();
    cmd_stop = 1'b1;
    cyc();
    cmd_stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    int r0;
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    cmd_play    = 1'b0;
    cmd_stop    = 1'b0;
    cmd_pause   = 1'b0;
    loop_en     = 1'b0;
    speed       = 4'b0100;
    start_addr  = '0;
    end_addr    = '0;
    #13;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_sample_out", 32'(sample_out), 32'h80);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Clip 10..12 at 1.0x: latency, then 0A, 0B, 0C, end of clip.
    expect_sample(8'h0A);
    play(10, 12, 4'b0100, 1'b0);
    check("lat_c1_valid", 32'(sample_valid), 32'd0);
    cyc();
    check("fetch_rd", 32'(mem_rd), 32'd1);
    check("fetch_addr", 32'(mem_addr), 32'd10);
    check("play_busy", 32'(busy), 32'd1);
    cyc();
    check("rd_one_cycle", 32'(mem_rd), 32'd0);
    check("lat_c2_valid", 32'(sample_valid), 32'd0);
    cyc();
    check("lat_c3_valid", 32'(sample_valid), 32'd1);
    wait_valid();
    tick_sample(8'h0B);
    tick_sample(8'h0C);
    tick_done();

    // Half speed repeats each address twice.
    expect_sample(8'h0A);
    play(10, 12, 4'b0010, 1'b0);
    wait_valid();
    tick_sample(8'h0A);
    tick_sample(8'h0B);
    tick_sample(8'h0B);
    tick_sample(8'h0C);
    tick_sample(8'h0C);
    tick_done();

    // Step 3.75 per tick over clip 0..7.
    expect_sample(8'h00);
    play(0, 7, 4'b1111, 1'b0);
    wait_valid();
    tick_sample(8'h03);
    tick_sample(8'h07);
    tick_done();

    // Zero speed refetches the same address.
    expect_sample(8'h03);
    play(3, 3, 4'b0000, 1'b0);
    wait_valid();
    tick_sample(8'h03);
    tick_sample(8'h03);
    stop();

    // Looping clip 5..6 never signals done.
    expect_sample(8'h05);
    play(5, 6, 4'b0100, 1'b1);
    wait_valid();
    d0 = n_done;
    tick_sample(8'h06);
    tick_sample(8'h05);
    tick_sample(8'h06);
    tick_sample(8'h05);
    check("loop_no_done", 32'(n_done), 32'(d0));
    stop();
    loop_en = 1'b0;

    // Pause at address 20, ticks ignored, resume refetches 20 then continues.
    expect_sample(8'h12);
    play(18, 30, 4'b0100, 1'b0);
    wait_valid();
    tick_sample(8'h13);
    tick_sample(8'h14);
    pause();
    check("pause_silence", 32'(sample_out), 32'h80);
    check("pause_busy", 32'(busy), 32'd1);
    r0 = rd_count;
    for (int i = 0; i < 3; i++) begin
      cyc(2);
      tick();
    end
    cyc(3);
    check("pause_no_rd", 32'(rd_count), 32'(r0));
    check("pause_no_valid", 32'(n_valid), 32'(exp_valid));
    check("pause_still_silent", 32'(sample_out), 32'h80);
    expect_sample(8'h14);
    pause();
    wait_valid();
    check("resume_addr", 32'(mem_addr), 32'd20);
    tick_sample(8'h15);
    stop();

    // Stop during WAIT_DATA discards the read.
    play(40, 50, 4'b0100, 1'b0);
    cyc();
    check("wait_data_rd", 32'(mem_rd), 32'd1);
    d0 = n_done;
    stop();
    check("stop_silence", 32'(sample_out), 32'h80);
    check("stop_mem_rd", 32'(mem_rd), 32'd0);
    cyc(6);
    check("stop_no_valid", 32'(n_valid), 32'(exp_valid));
    check("stop_no_done", 32'(n_done), 32'(d0));

    // Stop and play together: stop wins.
    expect_sample(8'h28);
    play(40, 50, 4'b0100, 1'b0);
    wait_valid();
    start_addr = 60;
    end_addr   = 70;
    cmd_stop   = 1'b1;
    cmd_play   = 1'b1;
    cyc();
    cmd_stop   = 1'b0;
    cmd_play   = 1'b0;
    check("stop_play_busy", 32'(busy), 32'd0);
    cyc(6);
    check("stop_play_no_valid", 32'(n_valid), 32'(exp_valid));
    check("stop_play_addr_held", 32'(mem_addr), 32'd40);

    // Asynchronous reset in FETCH takes effect before the next edge.
    play(40, 50, 4'b0100, 1'b0);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_mem_rd", 32'(mem_rd), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_sample_out", 32'(sample_out), 32'h80);
    check("arst_valid", 32'(sample_valid), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    #3;
    rst_n = 1'b1;
    cyc(4);
    check("arst_no_valid", 32'(n_valid), 32'(exp_valid));

    // Reversed clip window is ignored.
    r0 = rd_count;
    play(30, 20, 4'b0100, 1'b0);
    check("bad_clip_busy", 32'(busy), 32'd0);
    cyc(4);
    check("bad_clip_busy_later", 32'(busy), 32'd0);
    check("bad_clip_no_rd", 32'(rd_count), 32'(r0));
    check("bad_clip_no_valid", 32'(n_valid), 32'(exp_valid));

    // Tick in FETCH is held and serviced; a second tick in the same window is dropped.
    expect_sample(8'h0A);
    expect_sample(8'h0B);
    play(10, 20, 4'b0100, 1'b0);
    tick();
    tick();
    wait_valid();
    cyc(8);
    check("dropped_tick", 32'(n_valid), 32'(exp_valid));
    stop();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
